alu_issue: RTL
==============

Name: alu_issue

Overview:
Execute-side issue stage that turns decoded RV32I instruction fields into an ALU command: operand_a, operand_b and the 4-bit alu_control code the ALU consumes. It sits between decode and the ALU, with a valid/ready handshake on both sides and a 2-entry skid buffer, so decode stalls cleanly when execute back-pressures. It also flags unsupported opcodes.

Parameters:
XLEN, 32, operand and result width (only 32 is supported)
LINK_OFFSET, 4, constant added to pc for JAL link value

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all buffered entries
in_valid  input  1  decode presents an instruction
in_ready  output  1  issue stage can accept this cycle
opcode  input  7  instruction[6:0]
funct3  input  3  instruction[14:12]
funct7_5  input  1  instruction[30]
rs1_data  input  32  register file read port 1
rs2_data  input  32  register file read port 2
imm  input  32  sign-extended immediate from decode
pc  input  32  instruction address
out_valid  output  1  ALU command valid
out_ready  input  1  execute consumes command this cycle
operand_a  output  32  ALU operand A
operand_b  output  32  ALU operand B
alu_control  output  4  ALU operation code
illegal  output  1  command came from an unsupported opcode

Behaviour:
- alu_control encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, JALR 1010 (add, then clear bit 0).
- Decode is combinational on the input side. Result is registered:
  - OP 0110011: a=rs1, b=rs2. funct3 000: funct7_5 ? SUB : ADD. 001 SLL. 010 SLT. 011 SLTU. 100 XOR. 101: funct7_5 ? SRA : SRL. 110 OR. 111 AND.
  - OP-IMM 0010011: same map with b=imm, except 000 is always ADD. funct7_5 selects SRA on 101.
  - LOAD 0000011 / STORE 0100011: ADD, a=rs1, b=imm.
  - LUI 0110111: ADD, a=0, b=imm. AUIPC 0010111: ADD, a=pc, b=imm.
  - JAL 1101111: ADD, a=pc, b=LINK_OFFSET. JALR 1100111: JALR code, a=rs1, b=imm.
  - BRANCH 1100011: funct3 000/001 SUB; 100/101 SLT; 110/111 SLTU. a=rs1, b=rs2. funct3 010/011 is illegal.
  - Any other opcode: illegal=1, ADD, a=b=0. The command still flows through the handshake.
- Handshake: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready. out_valid must stay high and the payload stable until the output transfer.
- Storage: output register (main) plus one skid register.
  - in_ready is registered and equals !skid_valid.
  - Accept with main empty, or main draining this cycle with skid empty: write to main.
  - Accept while main is held (out_valid && !out_ready): write to skid, and in_ready drops next cycle.
  - Output transfer with skid full: skid moves to main and in_ready rises next cycle.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 per cycle when out_ready is held high. Program order is strictly preserved.
- Simultaneous accept and drain with skid full cannot occur, because in_ready=0.
- flush: at the next edge, main_valid=0 and skid_valid=0. Any input presented in the flush cycle is dropped, and in_ready=1 the following cycle. flush overrides out_ready; no output transfer is counted in a flush cycle.
- Reset (async, rst_n=0): out_valid=0, in_ready=1, illegal=0, operand_a=operand_b=0, alu_control=0000, skid cleared. Reset mid-transfer discards all entries. Outputs resume from empty after release.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> out_valid=0, in_ready=1, alu_control=0000, operands 0, immediately, asynchronously.
- OP SUB: opcode 0110011, funct3 000, funct7_5=1, rs1=7, rs2=3, out_ready=1 -> next cycle out_valid=1, alu_control=0001, a=7, b=3.
- SRAI / AUIPC / JAL: OP-IMM funct3 101, funct7_5=1, imm=4 -> alu_control=1001, b=4. AUIPC pc=0x100, imm=0x1000 -> ADD, a=0x100, b=0x1000. JAL pc=0x200 -> a=0x200, b=4.
- Back-pressure: out_ready=0, issue A then B -> A held on outputs, B in skid, in_ready=0. Raise out_ready -> A, then B on consecutive cycles, and in_ready returns to 1.
- Flush with both entries full -> next cycle out_valid=0, in_ready=1. An instruction offered in the flush cycle never appears.
- Illegal opcode 0001111 -> out_valid=1, illegal=1, alu_control=0000, a=b=0. The following legal instruction has illegal=0.

Source files
------------

// File: rtl/alu_issue_if.sv
// Decode-to-ALU issue bus: the input instruction fields with their valid/ready
// handshake, and the ALU command with its own valid/ready handshake.
interface alu_issue_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [3:0]      alu_control;
    logic            illegal;

    // Upstream/downstream agent view (decode + execute side)
    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc, out_ready,
        input  in_ready, out_valid, operand_a, operand_b, alu_control, illegal
    );

    // Issue stage view
    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc, out_ready,
        output in_ready, out_valid, operand_a, operand_b, alu_control, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I issue stage: decodes instruction fields into an ALU command and holds
// it in a main output register backed by a one-entry skid register.
module alu_issue #(
    parameter int          XLEN        = 32,
    parameter int unsigned LINK_OFFSET = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    alu_issue_if.slave  bus
);
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_JALR = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctrl;
        logic            illegal;
    } cmd_t;

    cmd_t dec, main_q, skid_q;
    logic main_valid, skid_valid;
    logic accept, drain;

    // Shared funct3 map for OP / OP-IMM; alt selects SUB on 000 and SRA on 101
    function automatic logic [3:0] f3_map(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_map = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_map = ALU_SLL;
            3'b010:  f3_map = ALU_SLT;
            3'b011:  f3_map = ALU_SLTU;
            3'b100:  f3_map = ALU_XOR;
            3'b101:  f3_map = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_map = ALU_OR;
            default: f3_map = ALU_AND;
        endcase
    endfunction

    // Combinational decode of the presented instruction
    always_comb begin
        dec = '0;
        case (bus.opcode)
            OPC_OP: begin
                dec.a    = bus.rs1_data;
                dec.b    = bus.rs2_data;
                dec.ctrl = f3_map(bus.funct3, bus.funct7_5);
            end
            OPC_OPIMM: begin
                // ADDI has no SUB form, so funct7_5 only matters on shifts-right
                dec.a    = bus.rs1_data;
                dec.b    = bus.imm;
                dec.ctrl = f3_map(bus.funct3, (bus.funct3 == 3'b101) && bus.funct7_5);
            end
            OPC_LOAD, OPC_STORE: begin
                dec.a = bus.rs1_data;
                dec.b = bus.imm;
            end
            OPC_LUI: begin
                dec.b = bus.imm;
            end
            OPC_AUIPC: begin
                dec.a = bus.pc;
                dec.b = bus.imm;
            end
            OPC_JAL: begin
                dec.a = bus.pc;
                dec.b = XLEN'(LINK_OFFSET);
            end
            OPC_JALR: begin
                dec.a    = bus.rs1_data;
                dec.b    = bus.imm;
                dec.ctrl = ALU_JALR;
            end
            OPC_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings: treated as illegal
                if (bus.funct3[2:1] == 2'b01) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.a    = bus.rs1_data;
                    dec.b    = bus.rs2_data;
                    dec.ctrl = (bus.funct3[2:1] == 2'b00) ? ALU_SUB :
                               (bus.funct3[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // in_ready is a pure function of the skid flop, so it is registered
    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid;
    assign drain        = main_valid && bus.out_ready;

    // Main/skid storage; skid only fills while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low here, so no accept can coincide with this drain
            if (drain) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || drain) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end else if (drain) begin
            main_valid <= 1'b0;
        end
    end

    assign bus.out_valid   = main_valid;
    assign bus.operand_a   = main_q.a;
    assign bus.operand_b   = main_q.b;
    assign bus.alu_control = main_q.ctrl;
    assign bus.illegal     = main_q.illegal;
endmodule
